q_result_fifo: RTL and testbench

Buffers the 8-bit results `q` produced by the `circuito` datapath and tags each one with its `L` flag bit. Results are only captured when the datapath marks them valid. The block sits directly downstream of `circuito`: its write side connects to `q`/`L` plus a valid strobe, and its read side feeds the next consumer with a valid/ready handshake. First-word fall-through; no data is ever dropped silently.

---
 rtl/q_result_pkg.sv | 16 +
 rtl/q_result_mem.sv | 34 +++
 rtl/q_result_fifo.sv | 94 +++++++++
 tb/tb_q_result_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/q_result_pkg.sv
// Shared definitions for the q result FIFO: entry layout and pointer sizing.
package q_result_pkg;

  localparam int Q_WIDTH = 8;
  localparam int Q_DEPTH = 4;

  // One stored entry: {flag, data}
  typedef logic [Q_WIDTH:0] entry_t;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int Q_PTR_W = ptr_width(Q_DEPTH);

endpackage

// File: rtl/q_result_mem.sv
// DEPTH x (WIDTH+1) register array: synchronous write, asynchronous read,
// cleared by the async active-low reset so the read port is never X.
module q_result_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH:0] rdata
);

  logic [WIDTH:0] mem_r [DEPTH];

  // Storage array with write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (we) begin
        mem_r[waddr] <= wdata;
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/q_result_fifo.sv
// First-word fall-through FIFO for circuito results {L, q}; occupancy is
// tracked by a counter, and writes while full set a sticky overflow flag.
module q_result_fifo
  import q_result_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int DEPTH = Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_flag,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_flag,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic [CW-1:0]  count_nxt_s;
  logic           overflow_r;
  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;
  logic [WIDTH:0] rdata_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});
  assign push_s  = in_valid && !full_s;
  assign pop_s   = !empty_s && out_ready;

  // Occupancy next-state from push/pop combination
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count and sticky overflow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
      if (in_valid && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  q_result_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({in_flag, in_data}),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign out_data  = rdata_s[WIDTH-1:0];
  assign out_flag  = rdata_s[WIDTH];
  assign count     = count_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_q_result_fifo.sv
// Self-checking bench for q_result_fifo: directed vector table, async-reset
// sequence, then random traffic against a queue-based reference model.
module tb_q_result_fifo;
  import q_result_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_flag;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_flag;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;

  int n_checks;
  int n_fail;

  q_result_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_flag   (in_flag),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_flag  (out_flag),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       f;
    logic       ordy;
    int         exp_cnt;
    logic       exp_ir;
    logic       exp_of;
    logic       chk_d;
    logic [7:0] exp_d;
    logic       exp_f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [7:0] d, logic f, logic ordy, int cnt,
                              logic of, logic chk, logic [7:0] ed, logic ef);
    vec_t v;
    v.iv = iv; v.d = d; v.f = f; v.ordy = ordy;
    v.exp_cnt = cnt; v.exp_ir = (cnt != DEPTH); v.exp_of = of;
    v.chk_d = chk; v.exp_d = ed; v.exp_f = ef;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic f, input logic ordy);
    in_valid = iv; in_data = d; in_flag = f; out_ready = ordy;
  endtask

  entry_t model_q[$];
  logic   model_of;

  initial begin
    vec_t v;
    int bias_v, bias_r;
    logic do_push, do_pop;

    n_checks = 0;
    n_fail   = 0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    #23;
    reset = 1'b1;
    step();
    step();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_overflow", overflow, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_flag", out_flag, 0);

    // iv d f ordy | count overflow chk_d data flag (state after the edge)
    vecs.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h55, 1'b0));
    vecs.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 2, 1'b0, 1'b1, 8'h55, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b1, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h01, 1'b0));
    vecs.push_back(mk(1'b1, 8'h02, 1'b1, 1'b0, 2, 1'b0, 1'b1, 8'h01, 1'b0));
    vecs.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b0, 1'b1, 8'h01, 1'b0));
    vecs.push_back(mk(1'b1, 8'h04, 1'b1, 1'b0, 4, 1'b0, 1'b1, 8'h01, 1'b0));
    vecs.push_back(mk(1'b1, 8'hAA, 1'b1, 1'b0, 4, 1'b1, 1'b1, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b1, 1'b1, 8'h02, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 1'b1, 8'h03, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b1, 8'h04, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h00, 1'b0));
    // prefill two, then six cycles of push+pop with 10..15 across wrap
    vecs.push_back(mk(1'b1, 8'hE0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'hE0, 1'b0));
    vecs.push_back(mk(1'b1, 8'hE1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 8'hE0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h10, 1'b0, 1'b1, 2, 1'b1, 1'b1, 8'hE1, 1'b1));
    vecs.push_back(mk(1'b1, 8'h11, 1'b1, 1'b1, 2, 1'b1, 1'b1, 8'h10, 1'b0));
    vecs.push_back(mk(1'b1, 8'h12, 1'b0, 1'b1, 2, 1'b1, 1'b1, 8'h11, 1'b1));
    vecs.push_back(mk(1'b1, 8'h13, 1'b1, 1'b1, 2, 1'b1, 1'b1, 8'h12, 1'b0));
    vecs.push_back(mk(1'b1, 8'h14, 1'b0, 1'b1, 2, 1'b1, 1'b1, 8'h13, 1'b1));
    vecs.push_back(mk(1'b1, 8'h15, 1'b1, 1'b1, 2, 1'b1, 1'b1, 8'h14, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b1, 8'h15, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h00, 1'b0));

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.iv, v.d, v.f, v.ordy);
      step();
      check($sformatf("vec%0d_count", i), count, v.exp_cnt);
      check($sformatf("vec%0d_out_valid", i), out_valid, (v.exp_cnt != 0));
      check($sformatf("vec%0d_in_ready", i), in_ready, v.exp_ir);
      check($sformatf("vec%0d_overflow", i), overflow, v.exp_of);
      if (v.chk_d) begin
        check($sformatf("vec%0d_out_data", i), out_data, v.exp_d);
        check($sformatf("vec%0d_out_flag", i), out_flag, v.exp_f);
      end
    end

    // async reset between edges with three entries held and overflow set
    drive(1'b1, 8'h31, 1'b1, 1'b0); step();
    drive(1'b1, 8'h32, 1'b0, 1'b0); step();
    drive(1'b1, 8'h33, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_arst_count", count, 3);
    check("pre_arst_overflow", overflow, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_count", count, 0);
    check("arst_overflow", overflow, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, 8'h00);
    #1;
    reset = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    step();
    check("post_arst_out_valid", out_valid, 1);
    check("post_arst_out_data", out_data, 8'h77);
    check("post_arst_count", count, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("post_arst_drain", count, 0);

    // random traffic against a queue model with phase-varying bias
    model_q.delete();
    model_of = 1'b0;
    for (int blk = 0; blk < 10; blk++) begin
      bias_v = $urandom_range(20, 90);
      bias_r = $urandom_range(20, 90);
      for (int c = 0; c < 50; c++) begin
        drive(($urandom_range(99) < bias_v), 8'($urandom), 1'($urandom),
              ($urandom_range(99) < bias_r));
        #1;
        check("rnd_in_ready", in_ready, (model_q.size() < DEPTH));
        check("rnd_out_valid", out_valid, (model_q.size() > 0));
        do_push = in_valid && (model_q.size() < DEPTH);
        do_pop  = out_ready && (model_q.size() > 0);
        if (in_valid && model_q.size() == DEPTH) model_of = 1'b1;
        step();
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back({in_flag, in_data});
        check("rnd_count", count, model_q.size());
        check("rnd_overflow", overflow, model_of);
        if (model_q.size() > 0) begin
          check("rnd_out_data", out_data, model_q[0][7:0]);
          check("rnd_out_flag", out_flag, model_q[0][8]);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
